// File: rtl/uart_wb_pkg.sv
// Shared types and helpers for the byte-wide Wishbone initiator: FSM states,
// byte-lane select mapping and timeout counter sizing.
package uart_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StGap
  } state_e;

  // One-hot lane select for a byte address; big-endian mirrors the lane order.
  function automatic logic [3:0] lane_to_sel(input logic [1:0] addr_lo,
                                             input bit little_endian);
    logic [1:0] lane;
    lane = little_endian ? addr_lo : (2'd3 - addr_lo);
    return 4'b0001 << lane;
  endfunction

  function automatic logic [1:0] sel_to_lane(input logic [3:0] sel);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) lane = 2'(i);
    end
    return lane;
  endfunction

  function automatic int unsigned timeout_cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/uart_wb_lane_steer.sv
// Combinational byte-lane steering: address to lane select, write byte
// replication and read byte extraction from the 32-bit bus.
module uart_wb_lane_steer
  import uart_wb_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic [1:0]  i_addr_lo,
  input  logic [7:0]  i_wdata,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [7:0]  o_rbyte
);

  logic [1:0] w_lane;

  always_comb begin
    o_sel   = lane_to_sel(i_addr_lo, LITTLE_ENDIAN);
    o_wdata = {4{i_wdata}};
    w_lane  = sel_to_lane(i_sel);
    o_rbyte = i_rdata[{w_lane, 3'b000} +: 8];
  end

endmodule

// File: rtl/uart_wb_master.sv
// Wishbone initiator issuing single byte register reads/writes with ack
// timeout and an enforced idle gap between bus cycles.
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter bit          LITTLE_ENDIAN = 1'b1,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned IDLE_GAP      = 2
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  rsp_err,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam int unsigned    CntW    = timeout_cnt_w(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [3:0]     GapInit = 4'(IDLE_GAP);

  state_e                r_state, w_state_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic [3:0]            r_gap, w_gap_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [7:0]            r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  r_cyc, w_cyc_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_adr, w_adr_nxt;
  logic [3:0]            r_sel, w_sel_nxt;
  logic [31:0]           r_dat, w_dat_nxt;

  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [7:0]  w_rbyte;

  uart_wb_lane_steer #(
    .LITTLE_ENDIAN(LITTLE_ENDIAN)
  ) u_steer (
    .i_addr_lo(cmd_addr[1:0]),
    .i_wdata  (cmd_wdata),
    .i_sel    (r_sel),
    .i_rdata  (wb_dat_i),
    .o_sel    (w_sel),
    .o_wdata  (w_wdata),
    .o_rbyte  (w_rbyte)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_gap_nxt       = r_gap;
    w_cmd_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = 8'h00;
    w_rsp_err_nxt   = 1'b0;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_adr_nxt       = r_adr;
    w_sel_nxt       = r_sel;
    w_dat_nxt       = r_dat;
    unique case (r_state)
      StIdle: begin
        // cmd_ready rises one cycle after entering IDLE, so it is low on the
        // response cycle and right after reset.
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt = StActive;
          w_cnt_nxt   = '0;
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = cmd_we;
          w_adr_nxt   = cmd_addr;
          w_sel_nxt   = w_sel;
          w_dat_nxt   = w_wdata;
        end else begin
          w_cmd_ready_nxt = 1'b1;
        end
      end
      StActive: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (wb_ack_i || (r_cnt == CntLast)) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = !wb_ack_i;
          w_rsp_rdata_nxt = (wb_ack_i && !r_we) ? w_rbyte : 8'h00;
          w_gap_nxt       = GapInit;
          w_state_nxt     = (IDLE_GAP == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (r_gap <= 4'd1) w_state_nxt = StIdle;
        else               w_gap_nxt   = r_gap - 1'b1;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_gap       <= 4'd0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_sel       <= 4'h0;
      r_dat       <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_adr       <= w_adr_nxt;
      r_sel       <= w_sel_nxt;
      r_dat       <= w_dat_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_cyc;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = r_adr;
  assign wb_sel_o  = r_sel;
  assign wb_dat_o  = r_dat;

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: little- and big-endian instances share stimulus
// and a bench-side slave; responses are compared against a transaction model.
module tb_uart_wb_master;

  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 8;
  localparam int unsigned GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cmd_valid, cmd_we, wb_ack_i;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_wdata;
  logic [31:0]   wb_dat_i;

  logic [1:0]    cmd_ready, rsp_valid, rsp_err, cyc, stb, we;
  logic [7:0]    rsp_rdata [2];
  logic [AW-1:0] adr [2];
  logic [3:0]    sel [2];
  logic [31:0]   dat [2];

  uart_wb_master #(.ADDR_WIDTH(AW), .LITTLE_ENDIAN(1'b1), .TIMEOUT(TMO), .IDLE_GAP(GAP)) u_le (
    .clk(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]), .wb_we_o(we[0]), .wb_adr_o(adr[0]),
    .wb_sel_o(sel[0]), .wb_dat_o(dat[0]), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  uart_wb_master #(.ADDR_WIDTH(AW), .LITTLE_ENDIAN(1'b0), .TIMEOUT(TMO), .IDLE_GAP(GAP)) u_be (
    .clk(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]), .wb_we_o(we[1]), .wb_adr_o(adr[1]),
    .wb_sel_o(sel[1]), .wb_dat_o(dat[1]), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    int          ack_d;  // stb cycle carrying ack; 0 = never
    logic [3:0]  sel_le, sel_be;
    logic [7:0]  rd_le, rd_be;
    logic        err;
    int          stbs;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: lane from byte address, response from ack timing vs timeout.
  function automatic vec_t model(input logic w, input logic [4:0] a, input logic [7:0] wd,
                                 input logic [31:0] rd, input int d);
    vec_t v;
    int   l_le, l_be;
    v.we = w; v.addr = a; v.wdata = wd; v.rdata = rd; v.ack_d = d;
    l_le = int'(a) % 4;
    l_be = 3 - l_le;
    v.sel_le = 4'(1 << l_le);
    v.sel_be = 4'(1 << l_be);
    v.err    = (d == 0) || (d > int'(TMO));
    v.stbs   = v.err ? int'(TMO) : d;
    v.rd_le  = (w || v.err) ? 8'h00 : 8'((rd >> (8 * l_le)) & 32'hFF);
    v.rd_be  = (w || v.err) ? 8'h00 : 8'((rd >> (8 * l_be)) & 32'hFF);
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input string tag);
    int n;
    int stbs;
    bit got;
    bit stable;
    n = 0;
    while (cmd_ready[0] !== 1'b1 && n < 40) begin step(); n++; end
    check({tag, " ready"}, cmd_ready, 2'b11);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata;
    wb_dat_i = v.rdata;
    step();
    cmd_valid = 1'b0;
    check({tag, " stb"}, {cyc, stb, cmd_ready}, 6'b111100);
    check({tag, " adr"}, {adr[1], adr[0]}, {v.addr, v.addr});
    check({tag, " we"}, we, {v.we, v.we});
    check({tag, " sel"}, {sel[1], sel[0]}, {v.sel_be, v.sel_le});
    check({tag, " dat"}, {dat[1], dat[0]}, {2{{4{v.wdata}}}});
    stbs = 0; got = 0; stable = 1;
    for (int i = 0; i < int'(TMO) + 6; i++) begin
      if (rsp_valid[0] === 1'b1) begin got = 1; break; end
      if (stb[0] === 1'b1) begin
        stbs++;
        if (sel[0] !== v.sel_le || adr[0] !== v.addr || dat[1] !== {4{v.wdata}}) stable = 0;
      end
      wb_ack_i = (stb[0] === 1'b1) && (stbs == v.ack_d);
      step();
    end
    wb_ack_i = 1'b0;
    check({tag, " rsp seen"}, got, 1);
    check({tag, " hold"}, stable, 1);
    check({tag, " stb cycles"}, stbs, v.stbs);
    check({tag, " rsp"}, {rsp_valid, rsp_err, cyc}, {2'b11, {v.err, v.err}, 2'b00});
    check({tag, " rdata"}, {rsp_rdata[1], rsp_rdata[0]}, {v.rd_be, v.rd_le});
    step();
    check({tag, " rsp width"}, rsp_valid, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    logic [39:0] hist;
    int run, bad, s0, f, s1;

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = 8'h00;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0;

    vecs[0] = '{1'b0, 5'h05, 8'h00, 32'h0000_6000, 3, 4'b0010, 4'b0100, 8'h60, 8'h00, 1'b0, 3};
    vecs[1] = '{1'b1, 5'h03, 8'hA5, 32'hFFFF_FFFF, 3, 4'b1000, 4'b0001, 8'h00, 8'h00, 1'b0, 3};
    vecs[2] = '{1'b0, 5'h1E, 8'h00, 32'h1122_3344, 1, 4'b0100, 4'b0010, 8'h22, 8'h33, 1'b0, 1};
    vecs[3] = '{1'b0, 5'h07, 8'h00, 32'h1234_5678, 0, 4'b1000, 4'b0001, 8'h00, 8'h00, 1'b1, 8};
    vecs[4] = '{1'b0, 5'h04, 8'h00, 32'hDEAD_BEEF, 8, 4'b0001, 4'b1000, 8'hEF, 8'hDE, 1'b0, 8};
    vecs[5] = '{1'b1, 5'h11, 8'h3C, 32'h0000_0000, 2, 4'b0010, 4'b0100, 8'h00, 8'h00, 1'b0, 2};

    step(); step();
    check("reset ctrl", {cmd_ready, rsp_valid, rsp_err, cyc, stb, we}, 12'h000);
    check("reset data", {rsp_rdata[0], rsp_rdata[1], adr[0], adr[1], sel[0], sel[1]}, 0);
    check("reset wdat", {dat[1], dat[0]}, 64'h0);
    rst = 1'b0;
    step();
    check("ready after reset", cmd_ready, 2'b11);

    // Stray ack while idle.
    bad = 0;
    wb_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (rsp_valid !== 2'b00) bad++; end
    wb_ack_i = 1'b0;
    check("stray ack idle rsp", bad, 0);
    check("stray ack idle state", {cmd_ready, cyc}, 4'b1100);

    for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Stray ack during the gap: ignored, ready still rises on schedule.
    do_txn(model(1'b0, 5'h02, 8'h00, 32'h00AB_0000, 3), "gap base");
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    check("stray ack gap", {rsp_valid, cyc, cmd_ready}, 6'b000000);
    step();
    check("ready after gap", {rsp_valid, cmd_ready}, 4'b0011);

    for (int i = 0; i < 40; i++) begin
      v = model(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), $urandom,
                int'($urandom_range(0, TMO + 1)));
      do_txn(v, $sformatf("rnd%0d", i));
    end

    // Back-to-back: cmd_valid held, slave acks on the 3rd stb cycle. Between
    // bursts: IDLE_GAP gap cycles plus the response cycle and the ready-rise cycle.
    while (cmd_ready[0] !== 1'b1) step();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'h02; wb_dat_i = 32'h0055_0000;
    run = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      hist[i] = stb[0];
      if (stb[0] && cmd_ready[0]) bad++;
      run = stb[0] ? run + 1 : 0;
      wb_ack_i = stb[0] && (run == 3);
      step();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && cmd_ready[0] !== 1'b1; i++) begin
      run = stb[0] ? run + 1 : 0;
      wb_ack_i = stb[0] && (run == 3);
      step();
    end
    wb_ack_i = 1'b0;
    s0 = -1; f = -1; s1 = -1;
    for (int i = 0; i < 40; i++) begin
      if (s0 < 0 && hist[i]) s0 = i;
      else if (s0 >= 0 && f < 0 && !hist[i]) f = i;
      else if (f >= 0 && s1 < 0 && hist[i]) s1 = i;
    end
    check("b2b ready vs stb", bad, 0);
    check("b2b stb burst", f - s0, 3);
    check("b2b low cycles", s1 - f, GAP + 2);

    // Reset in the middle of an active cycle.
    while (cmd_ready[0] !== 1'b1) step();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'h09; cmd_wdata = 8'h77;
    step();
    cmd_valid = 1'b0;
    step(); step();
    check("pre-reset active", stb, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid reset ctrl", {cyc, stb, cmd_ready, rsp_valid, we}, 10'h000);
    check("mid reset data", {sel[0], sel[1], dat[0], adr[0]}, 0);
    step();
    check("mid reset release", {cmd_ready, rsp_valid}, 4'b1100);
    do_txn(model(1'b0, 5'h0D, 8'h00, 32'h0000_9A00, 3), "post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
